xorshift32_rng: RTL and testbench

- 32-bit Marsaglia xorshift pseudo-random number generator with shift triple (13, 17, 5).
- Produces one new 32-bit word per clock from an internal state register that can be reseeded at run time.
- Used as the hardware uniform-random source feeding stochastic-computing datapaths.
- Output is the state register itself, so there is no extra pipeline stage.

---
 rtl/xorshift32_rng_if.sv | 12 +
 rtl/xorshift32_rng.sv | 41 ++++
 tb/tb_xorshift32_rng.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/xorshift32_rng_if.sv
// Seed/load/output bundle for the xorshift32 generator.
// master drives the seed and load strobe; slave (the generator) returns the random word.
interface xorshift32_rng_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] seed;
    logic             re_seed;
    logic [WIDTH-1:0] rnd;

    modport master (output seed, output re_seed, input rnd);
    modport slave  (input seed, input re_seed, output rnd);
endinterface

// File: rtl/xorshift32_rng.sv
// Marsaglia xorshift32 (13,17,5) uniform random source with run-time reseed.
// rnd is the state register itself, so a new word appears on every clock.
module xorshift32_rng #(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      SHIFT_A = 13,
    parameter int unsigned      SHIFT_B = 17,
    parameter int unsigned      SHIFT_C = 5,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    // Active-high despite the name; the codebase keeps this port name.
    input  logic             rst_n,
    xorshift32_rng_if.slave  bus
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] t1;
    logic [WIDTH-1:0] t2;
    logic [WIDTH-1:0] s_nxt;

    // One full xorshift step; shifted-out bits are simply dropped.
    always_comb begin
        t1    = s  ^ (s  << SHIFT_A);
        t2    = t1 ^ (t1 >> SHIFT_B);
        s_nxt = t2 ^ (t2 << SHIFT_C);
    end

    // Zero is a fixed point of the step; recovery relies on a software reseed.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s <= RST_VAL;
        end else if (bus.re_seed) begin
            s <= bus.seed;
        end else begin
            s <= s_nxt;
        end
    end

    assign bus.rnd = s;

endmodule

// File: tb/tb_xorshift32_rng.sv
// Directed bench for xorshift32_rng: a plain-arithmetic reference model checked
// every cycle, plus literal sequences that pin the model to known values.
module tb_xorshift32_rng;

    logic clk = 1'b0;
    logic rst = 1'b0;

    xorshift32_rng_if bus ();

    xorshift32_rng dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_chk    = 0;
    int          n_fail   = 0;
    bit          model_on = 1'b0;
    logic [31:0] model    = 32'h0;

    logic [31:0] seq_deadbeef [10] = '{32'd1199382711, 32'd2384302402, 32'd3129746520,
                                       32'd4276113467, 32'd1745748808, 32'd2760751131,
                                       32'd1649732188, 32'd486387635,  32'd2289630710,
                                       32'd1862841525};
    logic [31:0] seq_cafebabe [10] = '{32'd2827483434, 32'd2750467483, 32'd4064143354,
                                       32'd2526188539, 32'd1499439149, 32'd101746304,
                                       32'd3469816288, 32'd4115003222, 32'd1045250721,
                                       32'd1430002701};

    // Reference step written as modular arithmetic: x<<k is x*2^k mod 2^32.
    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [63:0] w;
        logic [31:0] a;
        logic [31:0] b;
        w = 64'(x) * 64'd8192;
        a = x ^ w[31:0];
        b = a ^ (a / 32'd131072);
        w = 64'(b) * 64'd32;
        return b ^ w[31:0];
    endfunction

    // Per-cycle comparison against the model once reset has defined the state.
    always @(negedge clk) begin
        if (model_on) begin
            n_chk++;
            if (bus.rnd !== model) begin
                n_fail++;
                $display("FAIL model_track t=%0t: got %h want %h", $time, bus.rnd, model);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] want);
        n_chk++;
        if (bus.rnd !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, bus.rnd, want);
        end
    endtask

    // One clock: model advances on the edge, inputs may change just after negedge.
    task automatic tick();
        @(posedge clk);
        if (rst)              model = 32'h0;
        else if (bus.re_seed) model = bus.seed;
        else                  model = xs_step(model);
        @(negedge clk);
        #1;
    endtask

    task automatic reseed(input logic [31:0] v);
        bus.seed    = v;
        bus.re_seed = 1'b1;
        tick();
        bus.re_seed = 1'b0;
    endtask

    initial begin
        bus.seed    = 32'h1234_5678;
        bus.re_seed = 1'b0;
        @(negedge clk);
        #1;

        // Reset pulse: state clears with no edge needed, stays at the zero fixed point.
        rst = 1'b1;
        #1;
        model    = 32'h0;
        model_on = 1'b1;
        check("reset_async", 32'h0);
        tick();
        check("reset_held", 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("zero_after_reset", 32'h0);
        end

        reseed(32'hDEAD_BEEF);
        check("load_deadbeef", 32'hDEAD_BEEF);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("deadbeef_seq[%0d]", i), seq_deadbeef[i]);
        end

        reseed(32'hCAFE_BABE);
        check("load_cafebabe", 32'hCAFE_BABE);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("cafebabe_seq[%0d]", i), seq_cafebabe[i]);
        end

        // Held load: output pinned to seed, advancing resumes after release.
        bus.seed    = 32'hDEAD_BEEF;
        bus.re_seed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_reseed", 32'hDEAD_BEEF);
        end
        bus.re_seed = 1'b0;
        tick();
        check("hold_release", seq_deadbeef[0]);
        tick();
        check("hold_release_2", seq_deadbeef[1]);

        // Asynchronous reset between edges, with a load pending that it must override.
        #2;
        bus.seed    = 32'h5555_AAAA;
        bus.re_seed = 1'b1;
        rst         = 1'b1;
        #1;
        model = 32'h0;
        check("reset_midstream", 32'h0);
        tick();
        check("reset_over_reseed", 32'h0);
        rst         = 1'b0;
        bus.re_seed = 1'b0;
        tick();
        check("post_reset_f0", 32'h0);
        reseed(32'hCAFE_BABE);
        check("reload_cafebabe", 32'hCAFE_BABE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("restart_seq[%0d]", i), seq_cafebabe[i]);
        end

        // Reseed with zero locks the generator at zero.
        reseed(32'h0);
        check("load_zero", 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("zero_lock", 32'h0);
        end

        // Free run from a fresh seed checked by the model alone.
        reseed(32'h0000_0001);
        for (int i = 0; i < 50; i++) tick();

        model_on = 1'b0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
